// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single-entry valid/ready stage with flush, bubble insertion
// and a saturating stall counter. Define LOAD_USE_STALL_EN to build the load-use interlock.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_b5,
  input  logic             in_MemWrite,
  input  logic             in_MemRead,
  input  logic             in_ALUsrc,
  input  logic             in_branch,
  input  logic             in_RegWrite,
  input  logic [1:0]       in_ALUop,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_rs1_data,
  output logic [XLEN-1:0]  out_rs2_data,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic             out_funct7_b5,
  output logic             out_MemWrite,
  output logic             out_MemRead,
  output logic             out_ALUsrc,
  output logic             out_branch,
  output logic             out_RegWrite,
  output logic [1:0]       out_ALUop,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic hazard;
  logic capture;

`ifdef LOAD_USE_STALL_EN
  // Dependent instruction waits until the load has left this register.
  assign hazard = out_valid & out_MemRead & (out_rd != 5'd0) & in_valid &
                  ((in_rs1 == out_rd) | (in_rs2 == out_rd));
`else
  assign hazard = 1'b0;
`endif

  assign in_ready = (~out_valid | out_ready) & ~flush & ~hazard;
  assign capture  = in_valid & in_ready;

  // Valid bit and control word: flush and drain both leave a bubble behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_MemWrite <= 1'b0;
      out_MemRead  <= 1'b0;
      out_ALUsrc   <= 1'b0;
      out_branch   <= 1'b0;
      out_RegWrite <= 1'b0;
      out_ALUop    <= 2'b00;
    end else if (flush) begin
      out_valid    <= 1'b0;
      out_MemWrite <= 1'b0;
      out_MemRead  <= 1'b0;
      out_ALUsrc   <= 1'b0;
      out_branch   <= 1'b0;
      out_RegWrite <= 1'b0;
      out_ALUop    <= 2'b00;
    end else if (capture) begin
      out_valid    <= 1'b1;
      out_MemWrite <= in_MemWrite;
      out_MemRead  <= in_MemRead;
      out_ALUsrc   <= in_ALUsrc;
      out_branch   <= in_branch;
      out_RegWrite <= in_RegWrite;
      out_ALUop    <= in_ALUop;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
      out_MemWrite <= 1'b0;
      out_MemRead  <= 1'b0;
      out_branch   <= 1'b0;
      out_RegWrite <= 1'b0;
      out_ALUop    <= 2'b00;
    end
  end

  // Payload only moves on capture; otherwise it holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pc        <= '0;
      out_rs1_data  <= '0;
      out_rs2_data  <= '0;
      out_imm       <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_funct3    <= '0;
      out_funct7_b5 <= 1'b0;
    end else if (capture) begin
      out_pc        <= in_pc;
      out_rs1_data  <= in_rs1_data;
      out_rs2_data  <= in_rs2_data;
      out_imm       <= in_imm;
      out_rs1       <= in_rs1;
      out_rs2       <= in_rs2;
      out_rd        <= in_rd;
      out_funct3    <= in_funct3;
      out_funct7_b5 <= in_funct7_b5;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (in_valid && !in_ready && stall_count != CntMax) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (built with CNT_W=4 to reach saturation).
module tb_id_ex_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]       in_rs1, in_rs2, in_rd;
  logic [2:0]       in_funct3;
  logic             in_funct7_b5;
  logic             in_MemWrite, in_MemRead, in_ALUsrc, in_branch, in_RegWrite;
  logic [1:0]       in_ALUop;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic [2:0]       out_funct3;
  logic             out_funct7_b5;
  logic             out_MemWrite, out_MemRead, out_ALUsrc, out_branch, out_RegWrite;
  logic [1:0]       out_ALUop;
  logic [CNT_W-1:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage #(
    .XLEN (XLEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .in_imm       (in_imm),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .in_funct3    (in_funct3),
    .in_funct7_b5 (in_funct7_b5),
    .in_MemWrite  (in_MemWrite),
    .in_MemRead   (in_MemRead),
    .in_ALUsrc    (in_ALUsrc),
    .in_branch    (in_branch),
    .in_RegWrite  (in_RegWrite),
    .in_ALUop     (in_ALUop),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_imm      (out_imm),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_funct3   (out_funct3),
    .out_funct7_b5(out_funct7_b5),
    .out_MemWrite (out_MemWrite),
    .out_MemRead  (out_MemRead),
    .out_ALUsrc   (out_ALUsrc),
    .out_branch   (out_branch),
    .out_RegWrite (out_RegWrite),
    .out_ALUop    (out_ALUop),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // An empty register must never carry memory/writeback/branch side effects.
  always @(negedge clk) begin
    if (!rst && !out_valid)
      check("bubble_ctrl", {60'd0, out_MemWrite, out_MemRead, out_branch, out_RegWrite}, 64'd0);
  end

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mw, input logic mr, input logic asrc,
                       input logic rw, input logic [1:0] aop);
    in_pc        = pc;
    in_rs1_data  = pc ^ 32'hA5A5_0000;
    in_rs2_data  = pc ^ 32'h0000_5A5A;
    in_imm       = pc + 32'd7;
    in_rs1       = rs1;
    in_rs2       = rs2;
    in_rd        = rd;
    in_funct3    = pc[4:2];
    in_funct7_b5 = pc[2];
    in_MemWrite  = mw;
    in_MemRead   = mr;
    in_ALUsrc    = asrc;
    in_branch    = 1'b0;
    in_RegWrite  = rw;
    in_ALUop     = aop;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    drive(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick(); tick();
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_stall", {60'd0, stall_count}, 64'd0);
    rst = 1'b0;
    tick();

    // Stream four R-type instructions back to back.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(32'h100 + 32'(4 * i), 5'(i + 10), 5'(i + 20), 5'(i + 1), 1'b0, 1'b0, 1'b0, 1'b1,
            2'b10);
      in_valid = 1'b1;
      #1;
      check("rtype_in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      check("rtype_valid", {63'd0, out_valid}, 64'd1);
      check("rtype_pc", {32'd0, out_pc}, {32'd0, 32'h100 + 32'(4 * i)});
      check("rtype_rd", {59'd0, out_rd}, {59'd0, 5'(i + 1)});
      check("rtype_rs1d", {32'd0, out_rs1_data}, {32'd0, (32'h100 + 32'(4 * i)) ^ 32'hA5A5_0000});
      check("rtype_imm", {32'd0, out_imm}, {32'd0, 32'h100 + 32'(4 * i) + 32'd7});
      check("rtype_ctrl", {60'd0, out_RegWrite, out_MemRead, out_ALUop}, 64'b1010);
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", {63'd0, out_valid}, 64'd0);
    check("drain_aluop", {62'd0, out_ALUop}, 64'd0);
    check("drain_regwr", {63'd0, out_RegWrite}, 64'd0);
    check("drain_pc_hold", {32'd0, out_pc}, 64'h10C);
    check("stream_stall", {60'd0, stall_count}, 64'd0);

    // Load a store, then backpressure for three cycles.
    out_ready = 1'b0;
    drive(32'h200, 5'd2, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    in_valid = 1'b1;
    tick();
    check("store_valid", {63'd0, out_valid}, 64'd1);
    drive(32'h300, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      check("bp_pc_frozen", {32'd0, out_pc}, 64'h200);
      check("bp_mw_frozen", {62'd0, out_MemWrite, out_ALUsrc}, 64'b11);
      check("bp_stall", {60'd0, stall_count}, 64'(i + 1));
    end

    // Flush kills the held store and the incoming instruction.
    flush = 1'b1;
    #1;
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_mw", {63'd0, out_MemWrite}, 64'd0);
    check("flush_stall", {60'd0, stall_count}, 64'd4);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    check("flush_dropped", {63'd0, out_valid}, 64'd0);
    check("flush_pc_not_b", {63'd0, out_pc == 32'h300}, 64'd0);

    // Asynchronous reset between edges while an instruction is held.
    drive(32'h280, 5'd1, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    in_valid = 1'b1;
    tick();
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_regwr", {63'd0, out_RegWrite}, 64'd0);
    check("arst_aluop", {62'd0, out_ALUop}, 64'd0);
    check("arst_stall", {60'd0, stall_count}, 64'd0);
    check("arst_pc", {32'd0, out_pc}, 64'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // lw x5 followed by add x6,x5,x1.
    out_ready = 1'b1;
    drive(32'h400, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    in_valid = 1'b1;
    tick();
    check("lw_valid", {63'd0, out_valid}, 64'd1);
    check("lw_rd", {59'd0, out_rd}, 64'd5);
    drive(32'h404, 5'd5, 5'd1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
`ifdef LOAD_USE_STALL_EN
    #1;
    check("lu_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    check("lu_bubble", {63'd0, out_valid}, 64'd0);
    check("lu_stall", {60'd0, stall_count}, 64'd1);
    tick();
`else
    tick();
    check("lu_stall", {60'd0, stall_count}, 64'd0);
`endif
    check("add_valid", {63'd0, out_valid}, 64'd1);
    check("add_rd", {59'd0, out_rd}, 64'd6);
    check("add_pc", {32'd0, out_pc}, 64'h404);
    in_valid = 1'b0;
    tick();

    // Saturation: 2^CNT_W+5 stall cycles after a fresh reset.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    out_ready = 1'b0;
    drive(32'h500, 5'd7, 5'd8, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    in_valid = 1'b1;
    tick();
    check("sat_load", {63'd0, out_valid}, 64'd1);
    for (int i = 1; i <= (1 << CNT_W) + 5; i++) begin
      tick();
      if (i == 14) check("sat_14", {60'd0, stall_count}, 64'd14);
    end
    check("sat_final", {60'd0, stall_count}, 64'd15);
    check("sat_pc_held", {32'd0, out_pc}, 64'h500);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
